// File: rtl/pcs_pkg.sv
// pcs_pkg: constants and helpers shared by the 10GBASE-R PCS gearboxes and
// the receive block-lock logic.
//   GEARBOX_SEQ_MAX : last value of the 33-cycle gearbox sequence counter
//   SH_*            : sync header width and its two legal encodings
//   BLOCK_WIDTH     : 64b/66b block size in bits
//   WORD_WIDTH      : transceiver word width
package pcs_pkg;

  localparam int unsigned GEARBOX_SEQ_MAX = 32;
  localparam int unsigned SH_WIDTH        = 2;
  localparam logic [1:0]  SH_DATA         = 2'b01;
  localparam logic [1:0]  SH_CTRL         = 2'b10;
  localparam int unsigned BLOCK_WIDTH     = 66;
  localparam int unsigned WORD_WIDTH      = 32;

  // A sync header is legal only as 01 (data block) or 10 (control block).
  function automatic logic sh_valid(input logic [SH_WIDTH-1:0] sh);
    return (sh == SH_DATA) || (sh == SH_CTRL);
  endfunction

endpackage

// File: rtl/tx_gearbox_if.sv
// tx_gearbox_if: block-side word bus of the transmit gearbox.
//   i_header     : 2-bit sync header (meaningful on header-half words only)
//   i_data       : 32-bit payload half
//   o_ready      : word accepted at this edge when high
//   o_data       : gearboxed 32-bit word, bit 0 transmitted first
//   o_header_err : invalid sync header seen on an accepted header half
// master = upstream block source, slave = gearbox.
interface tx_gearbox_if;
  import pcs_pkg::*;

  logic [SH_WIDTH-1:0]   i_header;
  logic [WORD_WIDTH-1:0] i_data;
  logic                  o_ready;
  logic [WORD_WIDTH-1:0] o_data;
  logic                  o_header_err;

  modport master (
    output i_header, i_data,
    input  o_ready, o_data, o_header_err
  );

  modport slave (
    input  i_header, i_data,
    output o_ready, o_data, o_header_err
  );

endinterface

// File: rtl/tx_gearbox.sv
// tx_gearbox: 10GBASE-R transmit 64b/66b gearbox. Takes each 66-bit block as
// two 32-bit halves (header half carries the sync header plus payload [31:0],
// data half carries payload [63:32]) and emits a continuous 32-bit stream.
// Sixteen blocks fill exactly 33 words, so upstream is paused one cycle in 33.
// Ports:
//   i_clk     : transmit clock
//   i_reset_n : asynchronous active-low reset
//   bus       : tx_gearbox_if slave (i_header, i_data, o_ready, o_data,
//               o_header_err)
// Build option: define TX_GEARBOX_HDR_CHECK_EN to flag accepted header halves
// whose sync header is 00 or 11 on o_header_err; otherwise it is tied low.
module tx_gearbox
  import pcs_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_reset_n,
  tx_gearbox_if.slave  bus
);

  localparam logic [5:0] SEQ_LAST = 6'(GEARBOX_SEQ_MAX);

  logic [5:0]  seq_q, seq_d;
  logic        half_q, half_d;
  logic [5:0]  cnt_q, cnt_d;     // valid residue bits, 0..32 between cycles
  logic [33:0] res_q, res_d;     // residue, LSB is the next bit to send
  logic [31:0] data_q, data_d;

  logic        accept_s;
  logic [65:0] in_bits_s;
  logic [5:0]  in_len_s;
  logic [65:0] merged_s;

  assign accept_s    = (seq_q != SEQ_LAST);
  assign bus.o_ready = accept_s;
  assign bus.o_data  = data_q;

  // Next-state: sequence counter, half flag, residue append and 32-bit drain.
  always_comb begin
    seq_d     = seq_q;
    half_d    = half_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    data_d    = data_q;
    in_bits_s = 66'd0;
    in_len_s  = 6'd0;

    if (seq_q >= SEQ_LAST) begin
      seq_d = 6'd0;
    end else begin
      seq_d = seq_q + 6'd1;
    end

    if (accept_s) begin
      half_d = ~half_q;
      if (!half_q) begin
        in_bits_s = {32'd0, bus.i_data, bus.i_header};
        in_len_s  = 6'd34;
      end else begin
        in_bits_s = {34'd0, bus.i_data};
        in_len_s  = 6'd32;
      end
    end else begin
      half_d = half_q;
    end

    // New bits land just above the residue; the low word goes out now.
    merged_s = {32'd0, res_q} | (in_bits_s << cnt_q);
    data_d   = merged_s[31:0];

    if (accept_s) begin
      res_d = merged_s[65:32];
      // Wraps through 64 at cnt=30 plus a header half; the true result
      // never exceeds 32, so the modulo-64 difference is exact.
      cnt_d = cnt_q + in_len_s - 6'd32;
    end else begin
      // Pause cycle: exactly 32 residue bits remain and all are sent.
      res_d = 34'd0;
      cnt_d = 6'd0;
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      seq_q  <= 6'd0;
      half_q <= 1'b0;
      cnt_q  <= 6'd0;
      res_q  <= 34'd0;
      data_q <= 32'd0;
    end else begin
      seq_q  <= seq_d;
      half_q <= half_d;
      cnt_q  <= cnt_d;
      res_q  <= res_d;
      data_q <= data_d;
    end
  end

`ifdef TX_GEARBOX_HDR_CHECK_EN
  logic hdr_err_q, hdr_err_d;

  // Flag an illegal sync header only on an accepted header half.
  always_comb begin
    hdr_err_d = 1'b0;
    if (accept_s && !half_q) begin
      hdr_err_d = ~sh_valid(bus.i_header);
    end else begin
      hdr_err_d = 1'b0;
    end
  end

  // Header error register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      hdr_err_q <= 1'b0;
    end else begin
      hdr_err_q <= hdr_err_d;
    end
  end

  assign bus.o_header_err = hdr_err_q;
`else
  assign bus.o_header_err = 1'b0;
`endif

endmodule
